// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer
//   Command sequencer in front of the calculator ALU. Commands are buffered in a
//   small FIFO and issued one at a time: the opcode is driven for exactly one
//   clock edge, the ALU result/error is captured ALU_LAT edges later and handed
//   back as a response with a valid/ready handshake. After reset the
//   accumulator-clear opcode is issued once. A response with a nonzero error
//   code can optionally flush all queued work.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready             command handshake (ready = FIFO not full, not INIT)
//   cmd_opcode, cmd_p, cmd_q        command payload
//   rsp_valid/rsp_ready             response handshake
//   rsp_opcode, rsp_result, rsp_error  completed command opcode, ALU result, ALU error
//   alu_opcode, alu_p, alu_q        drive to the ALU
//   alu_out, alu_err                ALU result and error code
//   busy                            FSM not idle or FIFO non-empty
//   fifo_count                      FIFO occupancy
//   err_sticky, clear_err           sticky error flag and its synchronous clear
//   drop_cnt                        saturating count of commands discarded by flush
module calc_cmd_sequencer #(
  parameter int         DEPTH        = 4,
  parameter int         ALU_LAT      = 1,
  parameter logic [3:0] HOLD_OP      = 4'b0000,
  parameter logic [3:0] RESET_OP     = 4'b1100,
  parameter bit         FLUSH_ON_ERR = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_opcode,
  input  logic [31:0]              cmd_p,
  input  logic [31:0]              cmd_q,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [3:0]               rsp_opcode,
  output logic [31:0]              rsp_result,
  output logic [1:0]               rsp_error,
  output logic [3:0]               alu_opcode,
  output logic [31:0]              alu_p,
  output logic [31:0]              alu_q,
  input  logic [31:0]              alu_out,
  input  logic [1:0]               alu_err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     err_sticky,
  input  logic                     clear_err,
  output logic [7:0]               drop_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int WCW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(ALU_LAT - 1);
  localparam logic [CW-1:0]  FULL      = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_EXEC = 3'd2,
    S_WAIT = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            init_q, init_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;

  logic [3:0]      mem_op [DEPTH];
  logic [31:0]     mem_p  [DEPTH];
  logic [31:0]     mem_q  [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [3:0]      alu_op_q, alu_op_d;
  logic [31:0]     alu_p_q, alu_p_d;
  logic [31:0]     alu_q_q, alu_q_d;
  logic [3:0]      iss_op_q, iss_op_d;

  logic            rsp_valid_q, rsp_valid_d;
  logic [3:0]      rsp_op_q, rsp_op_d;
  logic [31:0]     rsp_res_q, rsp_res_d;
  logic [1:0]      rsp_err_q, rsp_err_d;
  logic            err_sticky_q, err_sticky_d;
  logic [7:0]      drop_q, drop_d;

  logic            push, pop, capture, flush;
  logic [8:0]      drop_sum;

  assign cmd_ready = (state_q != S_INIT) && (count_q < FULL);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign capture   = (state_q == S_WAIT) && (wcnt_q == WAIT_LAST);
  assign flush     = FLUSH_ON_ERR && capture && (alu_err != 2'b00);

  // FIFO storage carries no reset; occupancy is governed by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr_q] <= cmd_opcode;
      mem_p[wr_ptr_q]  <= cmd_p;
      mem_q[wr_ptr_q]  <= cmd_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      init_q       <= 1'b0;
      wcnt_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      alu_op_q     <= HOLD_OP;
      alu_p_q      <= '0;
      alu_q_q      <= '0;
      iss_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_op_q     <= '0;
      rsp_res_q    <= '0;
      rsp_err_q    <= '0;
      err_sticky_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      init_q       <= init_d;
      wcnt_q       <= wcnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      alu_op_q     <= alu_op_d;
      alu_p_q      <= alu_p_d;
      alu_q_q      <= alu_q_d;
      iss_op_q     <= iss_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_op_q     <= rsp_op_d;
      rsp_res_q    <= rsp_res_d;
      rsp_err_q    <= rsp_err_d;
      err_sticky_q <= err_sticky_d;
      drop_q       <= drop_d;
    end
  end

  // Next-state logic. INIT spends its first edge loading RESET_OP onto the
  // ALU bus and its second edge moving on, so the clear opcode is presented
  // for exactly one cycle and sampled by the ALU on the edge that leaves INIT.
  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_INIT: begin
        init_d = 1'b1;
        if (init_q) state_d = S_IDLE;
      end
      S_IDLE: if (count_q != '0) state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_WAIT;
        wcnt_d  = '0;
      end
      S_WAIT: begin
        if (wcnt_q == WAIT_LAST) state_d = S_RESP;
        else                     wcnt_d  = wcnt_q + WCW'(1);
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    alu_op_d     = HOLD_OP;
    alu_p_d      = alu_p_q;
    alu_q_d      = alu_q_q;
    iss_op_d     = iss_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_op_d     = rsp_op_q;
    rsp_res_d    = rsp_res_q;
    rsp_err_d    = rsp_err_q;
    err_sticky_d = err_sticky_q;
    drop_d       = drop_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    drop_sum     = {1'b0, drop_q} + 9'(count_q) + {8'd0, push};

    if (state_q == S_INIT && !init_q) alu_op_d = RESET_OP;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);

    // The popped entry goes straight onto the ALU bus; it is live during EXEC
    // and reverts to HOLD_OP on the following edge, operands held.
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      alu_op_d = mem_op[rd_ptr_q];
      alu_p_d  = mem_p[rd_ptr_q];
      alu_q_d  = mem_q[rd_ptr_q];
      iss_op_d = mem_op[rd_ptr_q];
    end

    if (capture) begin
      rsp_valid_d = 1'b1;
      rsp_op_d    = iss_op_q;
      rsp_res_d   = alu_out;
      rsp_err_d   = alu_err;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    if (capture && alu_err != 2'b00) err_sticky_d = 1'b1;
    else if (clear_err)              err_sticky_d = 1'b0;

    // Flush discards everything queued plus any push landing on the same
    // edge; no pop can coincide with a capture.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_opcode = rsp_op_q;
  assign rsp_result = rsp_res_q;
  assign rsp_error  = rsp_err_q;
  assign alu_opcode = alu_op_q;
  assign alu_p      = alu_p_q;
  assign alu_q      = alu_q_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_count = count_q;
  assign err_sticky = err_sticky_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
module tb_calc_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode = 4'd0;
  logic [31:0] cmd_p = 32'd0;
  logic [31:0] cmd_q = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [3:0]  rsp_opcode;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_error;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_p;
  logic [31:0] alu_q;
  logic [31:0] alu_out = 32'd0;
  logic [1:0]  alu_err = 2'd0;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        err_sticky;
  logic        clear_err = 1'b0;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  calc_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_p(cmd_p), .cmd_q(cmd_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_opcode(rsp_opcode),
    .rsp_result(rsp_result), .rsp_error(rsp_error),
    .alu_opcode(alu_opcode), .alu_p(alu_p), .alu_q(alu_q),
    .alu_out(alu_out), .alu_err(alu_err),
    .busy(busy), .fifo_count(fifo_count),
    .err_sticky(err_sticky), .clear_err(clear_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Simple ALU stand-in: one registered stage, HOLD keeps the last result.
  function automatic logic [31:0] ipow(input logic [31:0] b, input logic [31:0] e);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < 32; i++) if (32'(i) < e) r = r * b;
    return r;
  endfunction

  always @(posedge clk) begin
    case (alu_opcode)
      4'b0000: ;
      4'b1100: begin alu_out <= 32'd0; alu_err <= 2'b00; end
      4'b0001: begin alu_out <= alu_p + alu_q; alu_err <= 2'b00; end
      4'b1111: begin alu_out <= ipow(alu_p, alu_q); alu_err <= 2'b00; end
      4'b0011: begin
        if (alu_q == 32'd0) begin alu_out <= 32'd0; alu_err <= 2'b01; end
        else begin alu_out <= alu_p / alu_q; alu_err <= 2'b00; end
      end
      default: begin alu_out <= 32'd0; alu_err <= 2'b10; end
    endcase
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] p;
    logic [31:0] q;
    logic [31:0] res;
    logic [1:0]  err;
  } vec_t;

  vec_t tv[7];
  vec_t t3[5];
  vec_t t6[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] p, input logic [31:0] q,
                      output logic ok);
    ok = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_p = p; cmd_q = q;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic take_rsp(output logic [3:0] op, output logic [31:0] res,
                          output logic [1:0] err, output logic ok, output int seen);
    ok = 1'b0; op = '0; res = '0; err = '0; seen = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1; op = rsp_opcode; res = rsp_result; err = rsp_error; seen = cyc;
      end
    end
    if (ok) begin
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  task automatic expect_rsp(input string name, input vec_t v);
    logic [3:0] op; logic [31:0] res; logic [1:0] err; logic ok; int seen;
    take_rsp(op, res, err, ok, seen);
    chk({name, "_seen"}, 32'(ok), 32'd1);
    chk({name, "_op"}, 32'(op), 32'(v.op));
    chk({name, "_res"}, res, v.res);
    chk({name, "_err"}, 32'(err), 32'(v.err));
  endtask

  task automatic observe(input int n, output int n_rop, output int n_rv, output int n_rdy);
    n_rop = 0; n_rv = 0; n_rdy = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (alu_opcode == 4'b1100) begin
        n_rop++;
        if (cmd_ready) n_rdy++;
      end
      if (rsp_valid) n_rv++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic ok;
    logic [3:0] op; logic [31:0] res; logic [1:0] err; int seen;
    int c0, n_rop, n_rv, n_rdy;

    tv[0] = '{4'b1100, 32'd0,          32'd0,  32'd0,    2'b00};
    tv[1] = '{4'b1111, 32'd35,         32'd2,  32'd1225, 2'b00};
    tv[2] = '{4'b0001, 32'd3,          32'd4,  32'd7,    2'b00};
    tv[3] = '{4'b0011, 32'd100,        32'd4,  32'd25,   2'b00};
    tv[4] = '{4'b0001, 32'hFFFF_FFFF,  32'd1,  32'd0,    2'b00};
    tv[5] = '{4'b1111, 32'd2,          32'd10, 32'd1024, 2'b00};
    tv[6] = '{4'b0011, 32'd7,          32'd0,  32'd0,    2'b01};

    t3[0] = '{4'b0001, 32'd1,   32'd1,  32'd2,   2'b00};
    t3[1] = '{4'b0001, 32'd2,   32'd3,  32'd5,   2'b00};
    t3[2] = '{4'b0001, 32'd10,  32'd20, 32'd30,  2'b00};
    t3[3] = '{4'b0001, 32'd100, 32'd1,  32'd101, 2'b00};
    t3[4] = '{4'b0001, 32'd7,   32'd8,  32'd15,  2'b00};

    t6[0] = '{4'b0001, 32'd5,   32'd5,  32'd10,  2'b00};
    t6[1] = '{4'b1111, 32'd3,   32'd3,  32'd27,  2'b00};
    t6[2] = '{4'b0011, 32'd81,  32'd9,  32'd9,   2'b00};
    t6[3] = '{4'b0001, 32'd40,  32'd2,  32'd42,  2'b00};
    t6[4] = '{4'b1111, 32'd10,  32'd3,  32'd1000, 2'b00};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'h0);
    chk("rst_alu_p", alu_p, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_result", rsp_result, 32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("rst_fifo_count", 32'(fifo_count), 32'h0);
    chk("rst_err_sticky", 32'(err_sticky), 32'h0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);

    rst_n = 1'b1;
    observe(6, n_rop, n_rv, n_rdy);
    chk("init_reset_op_cycles", 32'(n_rop), 32'd1);
    chk("init_no_rsp", 32'(n_rv), 32'd0);
    chk("init_ready_low", 32'(n_rdy), 32'd0);
    chk("init_ready_after", 32'(cmd_ready), 32'd1);

    // Table-driven single commands from an idle, empty sequencer
    for (int i = 0; i < 7; i++) begin
      push(tv[i].op, tv[i].p, tv[i].q, ok);
      chk($sformatf("tv%0d_accept", i), 32'(ok), 32'd1);
      c0 = cyc;
      take_rsp(op, res, err, ok, seen);
      chk($sformatf("tv%0d_seen", i), 32'(ok), 32'd1);
      chk($sformatf("tv%0d_op", i), 32'(op), 32'(tv[i].op));
      chk($sformatf("tv%0d_res", i), res, tv[i].res);
      chk($sformatf("tv%0d_err", i), 32'(err), 32'(tv[i].err));
      chk($sformatf("tv%0d_latency", i), 32'(seen - c0), 32'd3);
    end
    @(negedge clk);
    chk("tv_err_sticky", 32'(err_sticky), 32'd1);
    chk("tv_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("tv_rsp_cleared", 32'(rsp_valid), 32'd0);
    chk("tv_busy_idle", 32'(busy), 32'd0);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("clear_err", 32'(err_sticky), 32'd0);

    // Back-pressure: 1 issued + DEPTH queued
    for (int i = 0; i < 5; i++) begin
      push(t3[i].op, t3[i].p, t3[i].q, ok);
      chk($sformatf("bp_accept%0d", i), 32'(ok), 32'd1);
    end
    chk("bp_fifo_count", 32'(fifo_count), 32'd4);
    chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) expect_rsp($sformatf("bp_rsp%0d", i), t3[i]);
    @(negedge clk);
    chk("bp_drained", 32'(fifo_count), 32'd0);

    // Error flush: errored command followed by two queued commands
    push(4'b0011, 32'd100, 32'd0, ok);
    push(4'b0001, 32'd1, 32'd2, ok);
    push(4'b0001, 32'd3, 32'd4, ok);
    take_rsp(op, res, err, ok, seen);
    chk("flush_rsp_seen", 32'(ok), 32'd1);
    chk("flush_rsp_op", 32'(op), 32'h3);
    chk("flush_rsp_err", 32'(err), 32'd1);
    chk("flush_err_sticky", 32'(err_sticky), 32'd1);
    chk("flush_drop_cnt", 32'(drop_cnt), 32'd2);
    chk("flush_fifo_empty", 32'(fifo_count), 32'd0);
    observe(10, n_rop, n_rv, n_rdy);
    chk("flush_no_more_rsp", 32'(n_rv), 32'd0);

    // Asynchronous reset while the command waits on the ALU
    push(4'b0001, 32'd1, 32'd1, ok);
    push(4'b0001, 32'd2, 32'd2, ok);
    @(posedge clk);
    #1;
    chk("arst_pre_count", 32'(fifo_count), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_fifo_count", 32'(fifo_count), 32'd0);
    chk("arst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("arst_err_sticky", 32'(err_sticky), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    observe(10, n_rop, n_rv, n_rdy);
    chk("arst_init_reset_op", 32'(n_rop), 32'd1);
    chk("arst_no_stale_rsp", 32'(n_rv), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);

    // Push on the same edge as an IDLE pop with count = DEPTH-1
    for (int i = 0; i < 4; i++) push(t6[i].op, t6[i].p, t6[i].q, ok);
    chk("wrap_pre_count", 32'(fifo_count), 32'd3);
    expect_rsp("wrap_rsp0", t6[0]);
    chk("wrap_count_before_pop", 32'(fifo_count), 32'd3);
    chk("wrap_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_opcode = t6[4].op; cmd_p = t6[4].p; cmd_q = t6[4].q;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    chk("wrap_count_same_edge", 32'(fifo_count), 32'd3);
    for (int i = 1; i < 5; i++) expect_rsp($sformatf("wrap_rsp%0d", i), t6[i]);
    @(negedge clk);
    chk("wrap_drained", 32'(fifo_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
